// File: rtl/axis_rr_arbiter.sv
// Round-robin N-to-1 arbiter for single-beat AXI-Stream sources with a registered output stage.
// Define AXIS_RR_ARB_ID_EN to add mif_tid, which carries the winning source index with each beat.
module axis_rr_arbiter #(
    parameter int TDATA_WIDTH = 32,
    parameter int NUM_SIF     = 4,
    localparam int IDX_W      = $clog2(NUM_SIF)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SIF-1:0]             sif_tvalid,
    input  logic [NUM_SIF*TDATA_WIDTH-1:0] sif_tdata,
    output logic [NUM_SIF-1:0]             sif_tready,
    output logic                           mif_tvalid,
    output logic [TDATA_WIDTH-1:0]         mif_tdata,
`ifdef AXIS_RR_ARB_ID_EN
    output logic [IDX_W-1:0]               mif_tid,
`endif
    input  logic                           mif_tready,
    input  logic                           invalidate
);

    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       winner;
    logic                   any;
    logic                   can_load;
    logic                   load;
    logic [TDATA_WIDTH-1:0] win_data;

    assign can_load = ~mif_tvalid | mif_tready;

    // Two passes give the wrapped scan order: first ptr..NUM_SIF-1, then 0..ptr-1.
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_SIF; i++) begin
            if (!any && i >= int'(ptr) && sif_tvalid[i]) begin
                any    = 1'b1;
                winner = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_SIF; i++) begin
            if (!any && i < int'(ptr) && sif_tvalid[i]) begin
                any    = 1'b1;
                winner = IDX_W'(i);
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_SIF; i++) begin
            if (winner == IDX_W'(i)) begin
                win_data = sif_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
            end
        end
    end

    always_comb begin
        sif_tready = '0;
        if (can_load && !invalidate && !rst && any) begin
            sif_tready[winner] = 1'b1;
        end
    end

    assign load = |(sif_tvalid & sif_tready);

    // Invalidate outranks load and drain; a simultaneous drain and load keeps mif_tvalid high.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mif_tvalid <= 1'b0;
            mif_tdata  <= '0;
            ptr        <= '0;
`ifdef AXIS_RR_ARB_ID_EN
            mif_tid    <= '0;
`endif
        end else if (invalidate) begin
            mif_tvalid <= 1'b0;
            ptr        <= '0;
        end else if (load) begin
            mif_tvalid <= 1'b1;
            mif_tdata  <= win_data;
            ptr        <= (winner == IDX_W'(NUM_SIF - 1)) ? '0 : winner + IDX_W'(1);
`ifdef AXIS_RR_ARB_ID_EN
            mif_tid    <= winner;
`endif
        end else if (mif_tready) begin
            mif_tvalid <= 1'b0;
        end
    end

endmodule
